// File: rtl/aes_pkg.sv
// Shared AES constants: state geometry, S-box tables and the iterative-stage state enum.
package aes_pkg;

  localparam int unsigned AES_STATE_W = 128;
  localparam int unsigned AES_BYTES   = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [7:0] SBOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam logic [7:0] INV_SBOX [0:255] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

endpackage

// File: rtl/sub_bytes_iter_if.sv
// Block-level handshake bundle: input channel (valid/ready/inv/data) and output channel.
interface sub_bytes_iter_if;
  import aes_pkg::*;

  logic                   in_valid;
  logic                   in_ready;
  logic                   inv;
  logic [AES_STATE_W-1:0] data;
  logic                   out_valid;
  logic                   out_ready;
  logic [AES_STATE_W-1:0] data_out;

  modport master (
    output in_valid, inv, data, out_ready,
    input  in_ready, out_valid, data_out
  );

  modport slave (
    input  in_valid, inv, data, out_ready,
    output in_ready, out_valid, data_out
  );
endinterface

// File: rtl/sub_bytes_iter_sbox_lane.sv
// One combinational S-box lane; inv selects the inverse table.
module sbox_lane
  import aes_pkg::*;
(
  input  logic [7:0] byte_in,
  input  logic       inv,
  output logic [7:0] byte_out
);

  assign byte_out = inv ? INV_SBOX[byte_in] : SBOX[byte_in];

endmodule

// File: rtl/sub_bytes_iter.sv
// Iterative (Inv)SubBytes: NUM_SBOX shared lanes walk the 16-byte state over 16/NUM_SBOX cycles.
module sub_bytes_iter
  import aes_pkg::*;
#(
  parameter int unsigned NUM_SBOX = 4
) (
  input  logic             clk,
  input  logic             rst,
  sub_bytes_iter_if.slave  bus
);

  localparam int unsigned ITERS = AES_BYTES / NUM_SBOX;
  localparam int unsigned CNT_W = (ITERS > 1) ? $clog2(ITERS) : 1;

  if (!(NUM_SBOX == 1 || NUM_SBOX == 2 || NUM_SBOX == 4 ||
        NUM_SBOX == 8 || NUM_SBOX == 16)) begin : g_bad_num_sbox
    $error("sub_bytes_iter: NUM_SBOX must be 1, 2, 4, 8 or 16");
  end

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [AES_STATE_W-1:0] work_q, work_d;
  logic                   inv_q, inv_d;
  logic                   in_ready_c;
  logic                   accept;

  logic [7:0] lane_in  [NUM_SBOX];
  logic [7:0] lane_out [NUM_SBOX];

  assign in_ready_c    = (state_q == IDLE) || ((state_q == DONE) && bus.out_ready);
  assign accept        = bus.in_valid && in_ready_c;
  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = (state_q == DONE);
  assign bus.data_out  = work_q;

  // Byte-select mux: lane i sees byte cnt*NUM_SBOX+i (byte 0 is the MSB).
  always_comb begin
    for (int i = 0; i < NUM_SBOX; i++) begin
      lane_in[i] = '0;
      for (int j = 0; j < ITERS; j++) begin
        if (cnt_q == CNT_W'(j)) begin
          lane_in[i] = work_q[AES_STATE_W-1-8*(j*NUM_SBOX+i) -: 8];
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_SBOX; g++) begin : g_lane
    sbox_lane u_lane (
      .byte_in  (lane_in[g]),
      .inv      (inv_q),
      .byte_out (lane_out[g])
    );
  end

  // Next-state: write-back demux in BUSY; accept overrides from IDLE or DONE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
    inv_d   = inv_q;

    unique case (state_q)
      BUSY: begin
        for (int i = 0; i < NUM_SBOX; i++) begin
          for (int j = 0; j < ITERS; j++) begin
            if (cnt_q == CNT_W'(j)) begin
              work_d[AES_STATE_W-1-8*(j*NUM_SBOX+i) -: 8] = lane_out[i];
            end
          end
        end
        if (cnt_q == CNT_W'(ITERS - 1)) begin
          state_d = DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        if (bus.out_ready && !bus.in_valid) begin
          state_d = IDLE;
        end
      end
      default: ;
    endcase

    if (accept) begin
      work_d  = bus.data;
      inv_d   = bus.inv;
      cnt_d   = '0;
      state_d = BUSY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      work_q  <= '0;
      inv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
      inv_q   <= inv_d;
    end
  end

endmodule
